// File: rtl/inst_loader_pkg.sv
// Shared definitions for the program-load path: FSM state encoding, default
// widths and the instruction word that ends a load.
package inst_loader_pkg;

    localparam int ADDRWIDTH = 8;
    localparam int UART_BITS = 8;
    localparam int WORD_BITS = 32;

    localparam logic [WORD_BITS-1:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

endpackage

// File: rtl/inst_loader_if.sv
// Bundle between the debug unit (UART bytes, start pulse) and the loader's
// instruction-memory write port and status outputs.
interface inst_loader_if
    import inst_loader_pkg::*;
#(
    parameter int N_BITS  = UART_BITS,
    parameter int NB_DATA = WORD_BITS,
    parameter int NB_ADDR = ADDRWIDTH
);
    logic               i_start;
    logic               i_rx_done;
    logic [N_BITS-1:0]  i_rx_data;
    logic [NB_DATA-1:0] o_inst_load;
    logic [NB_ADDR-1:0] o_address;
    logic               o_en_write;
    logic               o_busy;
    logic               o_done;
    logic               o_error;
    logic [NB_ADDR:0]   o_count;

    modport master (
        output i_start, i_rx_done, i_rx_data,
        input  o_inst_load, o_address, o_en_write, o_busy, o_done, o_error, o_count
    );

    modport slave (
        input  i_start, i_rx_done, i_rx_data,
        output o_inst_load, o_address, o_en_write, o_busy, o_done, o_error, o_count
    );
endinterface

// File: rtl/inst_loader_byte_packer.sv
// Shifts received bytes into an instruction word, first byte in the MSB, and
// flags the strobe that completes a word. The completed word is presented
// combinationally alongside word_valid so the caller can register it on the
// same edge that accepts the last byte.
module inst_loader_byte_packer
    import inst_loader_pkg::*;
#(
    parameter int NB_DATA = WORD_BITS,
    parameter int N_BITS  = UART_BITS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               enable,
    input  logic               rx_done,
    input  logic [N_BITS-1:0]  rx_data,
    output logic [1:0]         byte_cnt,
    output logic               word_valid,
    output logic [NB_DATA-1:0] word
);
    logic [NB_DATA-1:0] shreg;

    assign word       = {shreg[NB_DATA-N_BITS-1:0], rx_data};
    assign word_valid = enable && rx_done && (byte_cnt == 2'd3);

    // Accept one byte per strobe; clear drops any partial word and wins over a byte.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shreg    <= '0;
            byte_cnt <= 2'd0;
        end else if (enable && rx_done) begin
            shreg    <= word;
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/inst_loader.sv
// Program loader: packs UART bytes into instruction words and writes them to
// consecutive instruction-memory addresses starting at 0. A HALT word ends the
// load successfully; running past the last address or stalling mid-word ends
// it with an error. A new start pulse from DONE or ERR begins a fresh load.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int                 NB_DATA        = WORD_BITS,
    parameter int                 N_BITS         = UART_BITS,
    parameter int                 NB_ADDR        = ADDRWIDTH,
    parameter logic [NB_DATA-1:0] HALT_WORD      = HALT_WORD_DEF,
    parameter int                 TIMEOUT_CYCLES = 50000000,
    parameter int                 NB_TMO         = 26
) (
    input  logic         i_clock,
    input  logic         i_reset,
    inst_loader_if.slave bus
);
    localparam logic [NB_TMO-1:0] TMO_LAST = NB_TMO'(TIMEOUT_CYCLES - 1);

    state_t             state;
    logic [NB_ADDR-1:0] address;
    logic [NB_TMO-1:0]  tmo_cnt;
    logic [1:0]         byte_cnt;
    logic               word_valid;
    logic [NB_DATA-1:0] word;

    logic start_ok;
    logic write_last;
    logic packer_en;
    logic packer_clear;
    logic tmo_expire;

    // Start is only honoured when no load is in progress.
    assign start_ok = bus.i_start &&
                      ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));

    // The WRITE cycle that ends the load (HALT or last address) must not keep
    // a byte arriving alongside it.
    assign write_last = (state == ST_WRITE) &&
                        ((bus.o_inst_load == HALT_WORD) || (&address));

    assign packer_en    = (state == ST_RECV) || ((state == ST_WRITE) && !write_last);
    assign packer_clear = start_ok || write_last;

    // A partial word that sees no byte for TIMEOUT_CYCLES clocks is abandoned.
    assign tmo_expire = (state == ST_RECV) && (byte_cnt != 2'd0) &&
                        !bus.i_rx_done && (tmo_cnt == TMO_LAST);

    inst_loader_byte_packer #(
        .NB_DATA (NB_DATA),
        .N_BITS  (N_BITS)
    ) u_packer (
        .clk        (i_clock),
        .rst        (i_reset),
        .clear      (packer_clear),
        .enable     (packer_en),
        .rx_done    (bus.i_rx_done),
        .rx_data    (bus.i_rx_data),
        .byte_cnt   (byte_cnt),
        .word_valid (word_valid),
        .word       (word)
    );

    // Load FSM with registered write port and status outputs.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state           <= ST_IDLE;
            address         <= '0;
            bus.o_inst_load <= '0;
            bus.o_address   <= '0;
            bus.o_en_write  <= 1'b0;
            bus.o_busy      <= 1'b0;
            bus.o_done      <= 1'b0;
            bus.o_error     <= 1'b0;
            bus.o_count     <= '0;
        end else begin
            bus.o_en_write <= 1'b0;
            unique case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start_ok) begin
                        state       <= ST_RECV;
                        address     <= '0;
                        bus.o_count <= '0;
                        bus.o_busy  <= 1'b1;
                        bus.o_done  <= 1'b0;
                        bus.o_error <= 1'b0;
                    end
                end
                ST_RECV: begin
                    if (word_valid) begin
                        state           <= ST_WRITE;
                        bus.o_en_write  <= 1'b1;
                        bus.o_inst_load <= word;
                        bus.o_address   <= address;
                    end else if (tmo_expire) begin
                        state       <= ST_ERR;
                        bus.o_busy  <= 1'b0;
                        bus.o_error <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    bus.o_count <= bus.o_count + (NB_ADDR+1)'(1);
                    if (bus.o_inst_load == HALT_WORD) begin
                        state      <= ST_DONE;
                        bus.o_busy <= 1'b0;
                        bus.o_done <= 1'b1;
                    end else if (&address) begin
                        state       <= ST_ERR;
                        bus.o_busy  <= 1'b0;
                        bus.o_error <= 1'b1;
                    end else begin
                        state   <= ST_RECV;
                        address <= address + NB_ADDR'(1);
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    bus.o_busy <= 1'b0;
                end
            endcase
        end
    end

    // Idle-clock counter between bytes of one word; restarts on every byte.
    always_ff @(posedge i_clock) begin
        if (i_reset || (state != ST_RECV) || (byte_cnt == 2'd0) || bus.i_rx_done) begin
            tmo_cnt <= '0;
        end else if (!tmo_expire) begin
            tmo_cnt <= tmo_cnt + NB_TMO'(1);
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Testbench for inst_loader: a transaction-level model (byte queue, word and
// address counters, status flags) predicts every output each cycle, and
// directed scenarios pin the model with hand-computed values.
module tb_inst_loader;
    localparam int          NB_ADDR  = 2;
    localparam int          TMO      = 100;
    localparam logic [31:0] HALT     = 32'hFFFF_FFFF;
    localparam int          MAX_ADDR = (1 << NB_ADDR) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_rx_cyc = 0;

    inst_loader_if #(.N_BITS(8), .NB_DATA(32), .NB_ADDR(NB_ADDR)) bus ();

    inst_loader #(
        .NB_DATA        (32),
        .N_BITS         (8),
        .NB_ADDR        (NB_ADDR),
        .HALT_WORD      (HALT),
        .TIMEOUT_CYCLES (TMO),
        .NB_TMO         (8)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Free-running cycle stamp.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_loading = 0, m_done = 0, m_err = 0, m_pend = 0;
    logic [7:0]  m_bytes[$];
    int          m_addr_next = 0, m_words = 0, m_idle = 0, m_addr = 0;
    logic [31:0] m_load = '0;

    logic [31:0] log_data[$];
    int          log_addr[$];
    int          log_cyc[$];

    task automatic model_step();
        if (rst) begin
            m_loading = 0; m_done = 0; m_err = 0; m_pend = 0;
            m_addr_next = 0; m_words = 0; m_idle = 0; m_addr = 0; m_load = '0;
            m_bytes.delete();
        end else if (m_pend) begin
            m_pend = 0;
            m_words++;
            if (m_load == HALT) begin
                m_done = 1; m_loading = 0; m_bytes.delete();
            end else if (m_addr_next == MAX_ADDR) begin
                m_err = 1; m_loading = 0; m_bytes.delete();
            end else begin
                m_addr_next++;
                if (bus.i_rx_done) begin
                    m_bytes.push_back(bus.i_rx_data);
                    m_idle = 0;
                end
            end
        end else if (!m_loading) begin
            if (bus.i_start) begin
                m_loading = 1; m_done = 0; m_err = 0;
                m_addr_next = 0; m_words = 0; m_idle = 0;
                m_bytes.delete();
            end
        end else if (bus.i_rx_done) begin
            m_bytes.push_back(bus.i_rx_data);
            m_idle = 0;
            if (m_bytes.size() == 4) begin
                m_load = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                m_addr = m_addr_next;
                m_pend = 1;
                m_bytes.delete();
            end
        end else if (m_bytes.size() != 0) begin
            if (m_idle == TMO - 1) begin
                m_err = 1; m_loading = 0; m_bytes.delete();
            end else begin
                m_idle++;
            end
        end
    endtask

    // Compare on the falling edge, then advance the model with the inputs the
    // next rising edge will sample.
    initial begin
        forever begin
            @(negedge clk);
            chk("en_write",  32'(bus.o_en_write),  32'(m_pend));
            chk("inst_load", bus.o_inst_load,      m_load);
            chk("address",   32'(bus.o_address),   32'(m_addr));
            chk("busy",      32'(bus.o_busy),      32'(m_loading));
            chk("done",      32'(bus.o_done),      32'(m_done));
            chk("error",     32'(bus.o_error),     32'(m_err));
            chk("count",     32'(bus.o_count),     32'(m_words));
            if (bus.o_en_write === 1'b1) begin
                log_data.push_back(bus.o_inst_load);
                log_addr.push_back(int'(bus.o_address));
                log_cyc.push_back(cyc);
            end
            model_step();
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.i_rx_done = 1'b1;
        bus.i_rx_data = b;
        last_rx_cyc   = cyc;
        tick();
        bus.i_rx_done = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], gap);
    endtask

    task automatic pulse_start();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.o_busy === 1'b1 && n < 500) begin
            tick();
            n++;
        end
        chk("busy_bound", 32'(bus.o_busy), 32'd0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_en"},    32'(bus.o_en_write), 32'd0);
        chk({nm, "_load"},  bus.o_inst_load,     32'd0);
        chk({nm, "_addr"},  32'(bus.o_address),  32'd0);
        chk({nm, "_busy"},  32'(bus.o_busy),     32'd0);
        chk({nm, "_done"},  32'(bus.o_done),     32'd0);
        chk({nm, "_err"},   32'(bus.o_error),    32'd0);
        chk({nm, "_count"}, 32'(bus.o_count),    32'd0);
    endtask

    initial begin
        int base;
        int n;
        bus.i_start   = 1'b0;
        bus.i_rx_done = 1'b0;
        bus.i_rx_data = 8'h00;

        // Reset state
        repeat (2) tick();
        rst = 1'b0;
        chk_all_zero("reset");

        // Basic load
        base = log_data.size();
        pulse_start();
        chk("start_busy", 32'(bus.o_busy), 32'd1);
        send_word(32'h2001_0005, 1);
        send_word(HALT, 1);
        wait_idle();
        chk("basic_nwr", 32'(log_data.size() - base), 32'd2);
        if (log_data.size() == base + 2) begin
            chk("basic_d0", log_data[base],     32'h2001_0005);
            chk("basic_a0", 32'(log_addr[base]), 32'd0);
            chk("basic_d1", log_data[base+1],   32'hFFFF_FFFF);
            chk("basic_a1", 32'(log_addr[base+1]), 32'd1);
        end
        chk("basic_done",  32'(bus.o_done),  32'd1);
        chk("basic_count", 32'(bus.o_count), 32'd2);

        // Byte in DONE is ignored
        base = log_data.size();
        send_byte(8'hAA, 3);
        chk("done_ign_nwr",   32'(log_data.size() - base), 32'd0);
        chk("done_ign_count", 32'(bus.o_count), 32'd2);
        chk("done_ign_done",  32'(bus.o_done),  32'd1);

        // Byte order and write latency
        base = log_data.size();
        pulse_start();
        chk("restart_done_clr", 32'(bus.o_done), 32'd0);
        send_word(32'h1234_5678, 0);
        repeat (2) tick();
        chk("order_nwr", 32'(log_data.size() - base), 32'd1);
        if (log_data.size() == base + 1) begin
            chk("order_data", log_data[base], 32'h1234_5678);
            chk("order_addr", 32'(log_addr[base]), 32'd0);
            chk("order_lat",  32'(log_cyc[base] - last_rx_cyc), 32'd1);
        end
        send_word(HALT, 0);
        wait_idle();
        chk("order_count", 32'(bus.o_count), 32'd2);

        // Restart with only a HALT word
        base = log_data.size();
        pulse_start();
        send_word(HALT, 2);
        wait_idle();
        chk("halt_only_nwr", 32'(log_data.size() - base), 32'd1);
        if (log_data.size() == base + 1) begin
            chk("halt_only_addr", 32'(log_addr[base]), 32'd0);
        end
        chk("halt_only_count", 32'(bus.o_count), 32'd1);

        // Overflow at the last address
        base = log_data.size();
        pulse_start();
        for (int w = 1; w <= 4; w++) send_word(32'(w), 1);
        wait_idle();
        chk("ovf_nwr", 32'(log_data.size() - base), 32'd4);
        if (log_data.size() == base + 4) begin
            for (int w = 0; w < 4; w++) chk("ovf_addr", 32'(log_addr[base+w]), 32'(w));
        end
        chk("ovf_err",   32'(bus.o_error), 32'd1);
        chk("ovf_done",  32'(bus.o_done),  32'd0);
        chk("ovf_count", 32'(bus.o_count), 32'd4);
        send_byte(8'h55, 3);
        chk("err_ign_nwr", 32'(log_data.size() - base), 32'd4);

        // Inter-byte timeout
        base = log_data.size();
        pulse_start();
        chk("restart_err_clr", 32'(bus.o_error), 32'd0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        n = 0;
        while (bus.o_error !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk("tmo_err",    32'(bus.o_error), 32'd1);
        chk("tmo_clocks", 32'(cyc - last_rx_cyc - 1), 32'(TMO));
        chk("tmo_nwr",    32'(log_data.size() - base), 32'd0);

        // Reset mid-word
        pulse_start();
        send_byte(8'h10, 0);
        send_byte(8'h20, 0);
        send_byte(8'h30, 0);
        pulse_reset();
        chk_all_zero("midrst");
        base = log_data.size();
        send_word(32'hDEAD_BEEF, 0);
        repeat (3) tick();
        chk("midrst_nwr", 32'(log_data.size() - base), 32'd0);

        // Byte landing in the WRITE cycle starts the next word
        base = log_data.size();
        pulse_start();
        send_word(32'hA1B2_C3D4, 0);
        send_word(HALT, 0);
        wait_idle();
        chk("bb_nwr", 32'(log_data.size() - base), 32'd2);
        if (log_data.size() == base + 2) begin
            chk("bb_d0", log_data[base],   32'hA1B2_C3D4);
            chk("bb_d1", log_data[base+1], HALT);
            chk("bb_a1", 32'(log_addr[base+1]), 32'd1);
        end

        // Randomized traffic
        repeat (400) begin
            case ($urandom_range(0, 9))
                0, 1:    pulse_start();
                2, 3, 4: send_word($urandom(), $urandom_range(0, 2));
                5:       send_word(HALT, $urandom_range(0, 1));
                6, 8:    send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 3));
                7:       repeat ($urandom_range(0, 120)) tick();
                default: begin
                    if ($urandom_range(0, 7) == 0) pulse_reset();
                    else tick();
                end
            endcase
        end

        repeat (5) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Sits between the UART receiver and the pipeline's instruction-memory load port, inside the debug_unit program-load path.
- Assembles received bytes into 32-bit instruction words and drives o_inst_load, o_address and o_en_write for each word.
- Auto-increments the load address and ends the load when the HALT word is written.
- Flags overflow and inter-byte timeout as errors.

Parameters:
- NB_DATA, 32, instruction word width; must equal 4*N_BITS.
- N_BITS, 8, UART byte width.
- NB_ADDR, 8, instruction memory address width (word-addressed).
- HALT_WORD, 32'hFFFFFFFF, instruction that terminates loading.
- TIMEOUT_CYCLES, 50000000, maximum number of idle clocks allowed between bytes of one word.
- NB_TMO, 26, width of the timeout counter.

Ports:
- i_clock, in, 1, single system clock.
- i_reset, in, 1, synchronous, active-high reset.
- i_start, in, 1, one-cycle pulse from the debug FSM that begins a load at address 0.
- i_rx_done, in, 1, one-cycle strobe: i_rx_data holds a valid byte.
- i_rx_data, in, N_BITS, received byte.
- o_inst_load, out, NB_DATA, assembled instruction word.
- o_address, out, NB_ADDR, write address for o_inst_load.
- o_en_write, out, 1, one-cycle instruction-memory write strobe.
- o_busy, out, 1, high while in RECV or WRITE.
- o_done, out, 1, level: load completed with HALT written.
- o_error, out, 1, level: overflow or timeout occurred.
- o_count, out, NB_ADDR+1, number of words written in the current load.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all outputs 0; byte counter, timeout counter and shift register cleared. Reset mid-load abandons the partial word, and no write occurs.
- States are IDLE, RECV, WRITE, DONE, ERR.
- IDLE:
  - i_rx_done is ignored.
  - i_start -> RECV; address=0, count=0, byte_cnt=0.
- RECV, on i_rx_done:
  - shreg = {shreg[23:0], i_rx_data}; byte_cnt++. The first byte received is the MSB (big-endian).
  - When byte_cnt reaches 4, go to WRITE next cycle and reset byte_cnt to 0.
- RECV, timeout:
  - The timeout counter counts only while byte_cnt is 1..3. It clears on every i_rx_done.
  - When it reaches TIMEOUT_CYCLES-1 -> ERR.
  - With byte_cnt==0 the block waits indefinitely.
- WRITE (exactly 1 cycle):
  - o_en_write=1, o_inst_load=shreg, o_address=current address.
  - Next cycle: count++.
  - If shreg==HALT_WORD -> DONE.
  - Else if address==2**NB_ADDR-1 -> ERR (overflow; the word is still written).
  - Else address++ and return to RECV.
  - An i_rx_done arriving in the WRITE cycle is captured as byte 0 of the next word. It is not lost, but is discarded if the next state is DONE or ERR.
- Write data/address timing: o_inst_load and o_address are registered and stable in the strobe cycle. They hold their last value outside it.
- DONE:
  - o_done=1; o_count holds the final count.
  - i_start -> RECV with a fresh load (o_done clears the same edge).
  - i_rx_done is ignored.
- ERR:
  - o_error=1.
  - i_start restarts exactly as from DONE and clears o_error.
- i_start while in RECV or WRITE is ignored.
- Write-strobe rules: o_en_write never asserts outside WRITE. At most one write per 4 accepted bytes.
- Latency: the 4th byte's i_rx_done at edge N gives o_en_write high during cycle N+1.

Decomposition:
- Shared package (parameters.vh): state encodings, HALT_WORD, ADDRWIDTH (drives NB_ADDR), UART byte width.
- One natural sub-module, `byte_packer`: the 4-byte shift register plus byte counter, emitting word_valid. The FSM, address, count and timeout logic stay in inst_loader.

Test Plan:
- Basic load: start; send bytes 20 01 00 05 then FF FF FF FF -> writes 0x20010005@0 and 0xFFFFFFFF@1; o_done=1; o_count=2; exactly 2 o_en_write pulses.
- Byte order: send 12 34 56 78 -> o_inst_load=0x12345678 in the strobe cycle, exactly 1 clock after the 4th i_rx_done.
- Overflow: NB_ADDR=2; send 4 non-HALT words -> 4 writes at addresses 0..3, then o_error=1, o_done=0, o_count=4.
- Timeout: TIMEOUT_CYCLES=100; send 2 bytes then nothing -> o_error=1 at 100 clocks after the last byte; no write.
- Reset mid-word: send 3 bytes, assert i_reset 1 cycle -> all outputs 0, state IDLE; bytes received before the next i_start produce no write.
- Restart and ignored inputs: after DONE, pulse i_start and send a HALT word -> write at address 0, o_count=1. A byte sent in IDLE or DONE has no effect.
